// File: rtl/mem_loader.sv
// mem_loader: assembles a stream of bytes (high byte first) into 16-bit words.
// It writes each word to consecutive memory addresses starting at 0.
//
// Ports:
//   clk       system clock, rising-edge active
//   reset     asynchronous active-low reset
//   load_en   level, 1 = loading session active, 0 = end/abort session
//   byte_in   data byte, qualified by byte_vld
//   byte_vld  one-cycle strobe per byte
//   ld_we     memory write enable, one pulse per assembled word
//   ld_addr   memory write address (word index, zero-extended)
//   ld_data   memory write data {high byte, low byte}
//   busy      1 while in HI, LO or WRITE
//   done      sticky completion flag
//   err       sticky error flag (partial word or overflow)
//   word_cnt  number of words written in the current session
//
// All outputs are registered. The output process computes next values from the
// current state and next state, so each output lines up with the state it belongs to.
module mem_loader #(
  parameter int DEPTH = 256
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        load_en,
  input  logic [7:0]  byte_in,
  input  logic        byte_vld,
  output logic        ld_we,
  output logic [15:0] ld_addr,
  output logic [15:0] ld_data,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [15:0] word_cnt
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_HI    = 3'd1,
    S_LO    = 3'd2,
    S_WRITE = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  localparam logic [15:0] LAST_ADDR = 16'(DEPTH - 1);

  state_t      state_r;
  state_t      state_nx_s;
  logic [7:0]  hi_byte_r;
  logic [7:0]  hi_byte_nx_s;
  logic        ld_we_nx_s;
  logic [15:0] ld_addr_nx_s;
  logic [15:0] ld_data_nx_s;
  logic        busy_nx_s;
  logic        done_nx_s;
  logic        err_nx_s;
  logic [15:0] word_cnt_nx_s;
  logic        full_s;

  // The memory is full once the word at the last address is being written.
  assign full_s = (ld_addr == LAST_ADDR);

  // State register with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Next-state logic. A byte strobe wins over load_en=0 in HI and LO.
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (load_en) state_nx_s = S_HI;
        else         state_nx_s = S_IDLE;
      end
      S_HI: begin
        if (byte_vld)      state_nx_s = S_LO;
        else if (!load_en) state_nx_s = S_DONE;
        else               state_nx_s = S_HI;
      end
      S_LO: begin
        if (byte_vld)      state_nx_s = S_WRITE;
        else if (!load_en) state_nx_s = S_DONE;
        else               state_nx_s = S_LO;
      end
      S_WRITE: begin
        if (full_s)        state_nx_s = S_DONE;
        else if (byte_vld) state_nx_s = S_LO;
        else               state_nx_s = S_HI;
      end
      S_DONE: begin
        if (!load_en) state_nx_s = S_IDLE;
        else          state_nx_s = S_DONE;
      end
      default: state_nx_s = S_IDLE;
    endcase
  end

  // Output logic: next values for every registered output and the high-byte latch.
  always_comb begin
    hi_byte_nx_s  = hi_byte_r;
    ld_addr_nx_s  = ld_addr;
    ld_data_nx_s  = ld_data;
    done_nx_s     = done;
    err_nx_s      = err;
    word_cnt_nx_s = word_cnt;
    case (state_r)
      S_IDLE: begin
        if (load_en) begin
          ld_addr_nx_s  = 16'd0;
          word_cnt_nx_s = 16'd0;
          done_nx_s     = 1'b0;
          err_nx_s      = 1'b0;
        end else begin
          ld_addr_nx_s  = ld_addr;
        end
      end
      S_HI: begin
        if (byte_vld) hi_byte_nx_s = byte_in;
        else          hi_byte_nx_s = hi_byte_r;
      end
      S_LO: begin
        // A session ending mid-word drops the latched high byte and flags it.
        if (byte_vld)      ld_data_nx_s = {hi_byte_r, byte_in};
        else if (!load_en) err_nx_s     = 1'b1;
        else               ld_data_nx_s = ld_data;
      end
      S_WRITE: begin
        word_cnt_nx_s = word_cnt + 16'd1;
        if (full_s) begin
          // Address saturates at the last word; a byte arriving now has nowhere to go.
          if (byte_vld) err_nx_s = 1'b1;
          else          err_nx_s = err;
        end else begin
          ld_addr_nx_s = ld_addr + 16'd1;
          if (byte_vld) hi_byte_nx_s = byte_in;
          else          hi_byte_nx_s = hi_byte_r;
        end
      end
      S_DONE: begin
        if (load_en && byte_vld) err_nx_s = 1'b1;
        else                     err_nx_s = err;
      end
      default: begin
        hi_byte_nx_s = hi_byte_r;
      end
    endcase
    if (state_nx_s == S_DONE) done_nx_s = 1'b1;
    else                      done_nx_s = done_nx_s;
    ld_we_nx_s = (state_nx_s == S_WRITE);
    busy_nx_s  = (state_nx_s == S_HI) || (state_nx_s == S_LO) || (state_nx_s == S_WRITE);
  end

  // Output and datapath registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hi_byte_r <= 8'd0;
      ld_we     <= 1'b0;
      ld_addr   <= 16'd0;
      ld_data   <= 16'd0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      word_cnt  <= 16'd0;
    end else begin
      hi_byte_r <= hi_byte_nx_s;
      ld_we     <= ld_we_nx_s;
      ld_addr   <= ld_addr_nx_s;
      ld_data   <= ld_data_nx_s;
      busy      <= busy_nx_s;
      done      <= done_nx_s;
      err       <= err_nx_s;
      word_cnt  <= word_cnt_nx_s;
    end
  end

endmodule

// File: tb/tb_mem_loader.sv
// Directed testbench for mem_loader. Instance a uses the default DEPTH of 256.
// Instance b uses DEPTH=4 to exercise the memory-full path.
// Inputs change on the falling clock edge, and outputs are checked on the next falling edge.
// Completed writes are logged at the rising edge into per-instance queues.
module tb_mem_loader;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        load_en = 1'b0;
  logic        byte_vld = 1'b0;
  logic [7:0]  byte_in = 8'd0;
  logic        b_load_en = 1'b0;
  logic        b_byte_vld = 1'b0;
  logic [7:0]  b_byte_in = 8'd0;

  logic        ld_we, busy, done, err;
  logic [15:0] ld_addr, ld_data, word_cnt;
  logic        b_ld_we, b_busy, b_done, b_err;
  logic [15:0] b_ld_addr, b_ld_data, b_word_cnt;

  int tests_run = 0;
  int tests_failed = 0;

  logic [15:0] wr_addr_q[$];
  logic [15:0] wr_data_q[$];
  logic [15:0] b_wr_addr_q[$];
  logic [15:0] b_wr_data_q[$];

  mem_loader dut_a (
    .clk(clk), .reset(reset), .load_en(load_en), .byte_in(byte_in), .byte_vld(byte_vld),
    .ld_we(ld_we), .ld_addr(ld_addr), .ld_data(ld_data), .busy(busy), .done(done),
    .err(err), .word_cnt(word_cnt)
  );

  mem_loader #(.DEPTH(4)) dut_b (
    .clk(clk), .reset(reset), .load_en(b_load_en), .byte_in(b_byte_in), .byte_vld(b_byte_vld),
    .ld_we(b_ld_we), .ld_addr(b_ld_addr), .ld_data(b_ld_data), .busy(b_busy), .done(b_done),
    .err(b_err), .word_cnt(b_word_cnt)
  );

  always #5 clk = ~clk;

  // Write logger: a write happens at the rising edge that ends a cycle with ld_we high.
  always @(posedge clk) begin
    if (ld_we) begin
      wr_addr_q.push_back(ld_addr);
      wr_data_q.push_back(ld_data);
    end
    if (b_ld_we) begin
      b_wr_addr_q.push_back(b_ld_addr);
      b_wr_data_q.push_back(b_ld_data);
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic clear_logs();
    wr_addr_q.delete();
    wr_data_q.delete();
    b_wr_addr_q.delete();
    b_wr_data_q.delete();
  endtask

  task automatic test_reset();
    #1;
    tests_run++;
    if ({ld_we, ld_addr, ld_data, busy, done, err, word_cnt} !== 52'd0) begin
      tests_failed++;
      $display("FAIL reset_state_a: got we=%b addr=%h data=%h busy=%b done=%b err=%b cnt=%h, want all 0",
               ld_we, ld_addr, ld_data, busy, done, err, word_cnt);
    end
    tests_run++;
    if ({b_ld_we, b_ld_addr, b_ld_data, b_busy, b_done, b_err, b_word_cnt} !== 52'd0) begin
      tests_failed++;
      $display("FAIL reset_state_b: got nonzero outputs, want all 0");
    end
    tick();
    reset = 1'b1;
    repeat (3) tick();
    tests_run++;
    if (busy !== 1'b0 || wr_addr_q.size() != 0) begin
      tests_failed++;
      $display("FAIL idle_without_load_en: got busy=%b writes=%0d, want busy=0 writes=0", busy, wr_addr_q.size());
    end
  endtask

  task automatic test_two_words();
    clear_logs();
    load_en = 1'b1;
    tick();
    tests_run++;
    if (busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL start_busy: got %b want 1", busy);
    end
    byte_vld = 1'b1; byte_in = 8'h12; tick();
    byte_in = 8'h34; tick();
    tests_run++;
    if (ld_we !== 1'b1 || ld_data !== 16'h1234 || ld_addr !== 16'd0) begin
      tests_failed++;
      $display("FAIL word0_write: got we=%b data=%h addr=%h, want we=1 data=1234 addr=0", ld_we, ld_data, ld_addr);
    end
    byte_vld = 1'b0; tick();
    tests_run++;
    if (ld_we !== 1'b0 || ld_addr !== 16'd1 || word_cnt !== 16'd1) begin
      tests_failed++;
      $display("FAIL after_word0: got we=%b addr=%h cnt=%h, want we=0 addr=1 cnt=1", ld_we, ld_addr, word_cnt);
    end
    byte_vld = 1'b1; byte_in = 8'hAB; tick();
    byte_in = 8'hCD; tick();
    byte_vld = 1'b0; load_en = 1'b0; tick();
    tick();
    tests_run++;
    if (done !== 1'b1 || err !== 1'b0 || word_cnt !== 16'd2 || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL two_words_end: got done=%b err=%b cnt=%h busy=%b, want 1 0 2 0", done, err, word_cnt, busy);
    end
    tests_run++;
    if (wr_addr_q.size() != 2 || wr_addr_q[0] !== 16'd0 || wr_data_q[0] !== 16'h1234 ||
        wr_addr_q[1] !== 16'd1 || wr_data_q[1] !== 16'hABCD) begin
      tests_failed++;
      $display("FAIL two_words_log: got %0d writes, want 1234@0 ABCD@1", wr_addr_q.size());
    end
    repeat (2) tick();
    tests_run++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL done_retained_idle: got done=%b busy=%b, want 1 0", done, busy);
    end
  endtask

  task automatic test_partial();
    clear_logs();
    load_en = 1'b1; tick();
    byte_vld = 1'b1; byte_in = 8'h12; tick();
    byte_in = 8'h34; tick();
    byte_in = 8'h56; tick();
    byte_vld = 1'b0; load_en = 1'b0; tick();
    tests_run++;
    if (done !== 1'b1 || err !== 1'b1 || word_cnt !== 16'd1 || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL partial_end: got done=%b err=%b cnt=%h busy=%b, want 1 1 1 0", done, err, word_cnt, busy);
    end
    repeat (3) tick();
    tests_run++;
    if (wr_addr_q.size() != 1 || wr_addr_q[0] !== 16'd0 || wr_data_q[0] !== 16'h1234) begin
      tests_failed++;
      $display("FAIL partial_log: got %0d writes, want exactly 1234@0", wr_addr_q.size());
    end
  endtask

  task automatic test_second_session();
    clear_logs();
    load_en = 1'b1; tick();
    tests_run++;
    if (done !== 1'b0 || err !== 1'b0 || word_cnt !== 16'd0 || ld_addr !== 16'd0) begin
      tests_failed++;
      $display("FAIL session_clear: got done=%b err=%b cnt=%h addr=%h, want all 0", done, err, word_cnt, ld_addr);
    end
    byte_vld = 1'b1; byte_in = 8'hDE; tick();
    byte_in = 8'hAD; tick();
    tests_run++;
    if (ld_we !== 1'b1 || ld_addr !== 16'd0 || ld_data !== 16'hDEAD) begin
      tests_failed++;
      $display("FAIL session2_write: got we=%b addr=%h data=%h, want 1 0 DEAD", ld_we, ld_addr, ld_data);
    end
    byte_vld = 1'b0; load_en = 1'b0; tick();
    tick();
    tests_run++;
    if (done !== 1'b1 || err !== 1'b0 || word_cnt !== 16'd1) begin
      tests_failed++;
      $display("FAIL session2_end: got done=%b err=%b cnt=%h, want 1 0 1", done, err, word_cnt);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    logic [7:0] bytes [6];
    bytes = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    clear_logs();
    load_en = 1'b1; tick();
    for (int i = 0; i < 6; i++) begin
      byte_vld = 1'b1; byte_in = bytes[i]; tick();
      tests_run++;
      if (i % 2 == 1) begin
        if (ld_we !== 1'b1 || ld_data !== {bytes[i-1], bytes[i]} || ld_addr !== 16'(i / 2)) begin
          tests_failed++;
          $display("FAIL b2b_write%0d: got we=%b data=%h addr=%h, want we=1 data=%h addr=%0d",
                   i, ld_we, ld_data, ld_addr, {bytes[i-1], bytes[i]}, i / 2);
        end
      end else begin
        if (ld_we !== 1'b0) begin
          tests_failed++;
          $display("FAIL b2b_nowrite%0d: got we=%b want 0", i, ld_we);
        end
      end
    end
    byte_vld = 1'b0; load_en = 1'b0; tick();
    tick();
    tests_run++;
    if (word_cnt !== 16'd3 || err !== 1'b0 || done !== 1'b1 || wr_addr_q.size() != 3) begin
      tests_failed++;
      $display("FAIL b2b_end: got cnt=%h err=%b done=%b writes=%0d, want 3 0 1 3",
               word_cnt, err, done, wr_addr_q.size());
    end
    tick();
  endtask

  task automatic test_overflow();
    clear_logs();
    b_load_en = 1'b1; tick();
    for (int i = 0; i < 10; i++) begin
      b_byte_vld = 1'b1; b_byte_in = 8'(i + 1); tick();
      if (i == 7) begin
        tests_run++;
        if (b_ld_we !== 1'b1 || b_ld_addr !== 16'd3 || b_ld_data !== 16'h0708 || b_err !== 1'b0) begin
          tests_failed++;
          $display("FAIL full_last_write: got we=%b addr=%h data=%h err=%b, want 1 3 0708 0",
                   b_ld_we, b_ld_addr, b_ld_data, b_err);
        end
      end else if (i == 8) begin
        tests_run++;
        if (b_err !== 1'b1 || b_done !== 1'b1 || b_ld_we !== 1'b0) begin
          tests_failed++;
          $display("FAIL full_byte_in_write: got err=%b done=%b we=%b, want 1 1 0", b_err, b_done, b_ld_we);
        end
      end
    end
    b_byte_vld = 1'b0;
    tick();
    tests_run++;
    if (b_err !== 1'b1 || b_done !== 1'b1 || b_ld_addr !== 16'd3 || b_word_cnt !== 16'd4 || b_busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL overflow_end: got err=%b done=%b addr=%h cnt=%h busy=%b, want 1 1 3 4 0",
               b_err, b_done, b_ld_addr, b_word_cnt, b_busy);
    end
    b_load_en = 1'b0; repeat (2) tick();
    tests_run++;
    if (b_wr_addr_q.size() != 4) begin
      tests_failed++;
      $display("FAIL overflow_count: got %0d writes want 4", b_wr_addr_q.size());
    end else begin
      for (int k = 0; k < 4; k++) begin
        tests_run++;
        if (b_wr_addr_q[k] !== 16'(k) || b_wr_data_q[k] !== {8'(2 * k + 1), 8'(2 * k + 2)}) begin
          tests_failed++;
          $display("FAIL overflow_log%0d: got %h@%h, want %h@%0d", k, b_wr_data_q[k], b_wr_addr_q[k],
                   {8'(2 * k + 1), 8'(2 * k + 2)}, k);
        end
      end
    end
    tests_run++;
    if (b_done !== 1'b1 || b_err !== 1'b1) begin
      tests_failed++;
      $display("FAIL overflow_flags_idle: got done=%b err=%b want 1 1", b_done, b_err);
    end
  endtask

  task automatic test_reset_mid();
    clear_logs();
    load_en = 1'b1; tick();
    byte_vld = 1'b1; byte_in = 8'h77; tick();
    byte_vld = 1'b0;
    #2 reset = 1'b0;
    #1;
    tests_run++;
    if ({ld_we, ld_addr, ld_data, busy, done, err, word_cnt} !== 52'd0) begin
      tests_failed++;
      $display("FAIL async_reset_lo: got we=%b addr=%h data=%h busy=%b done=%b err=%b cnt=%h, want all 0",
               ld_we, ld_addr, ld_data, busy, done, err, word_cnt);
    end
    byte_vld = 1'b1; byte_in = 8'h88;
    tick(); tick();
    byte_vld = 1'b0; load_en = 1'b0; reset = 1'b1;
    tick(); tick();
    tests_run++;
    if (wr_addr_q.size() != 0 || busy !== 1'b0 || ld_we !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_no_write: got writes=%0d busy=%b we=%b, want 0 0 0", wr_addr_q.size(), busy, ld_we);
    end
    load_en = 1'b1; tick();
    byte_vld = 1'b1; byte_in = 8'h9A; tick();
    byte_in = 8'hBC; tick();
    tests_run++;
    if (ld_we !== 1'b1 || ld_addr !== 16'd0 || ld_data !== 16'h9ABC) begin
      tests_failed++;
      $display("FAIL restart_addr0: got we=%b addr=%h data=%h, want 1 0 9ABC", ld_we, ld_addr, ld_data);
    end
    byte_vld = 1'b0;
    #2 reset = 1'b0;
    #1;
    tests_run++;
    if (ld_we !== 1'b0 || busy !== 1'b0 || ld_data !== 16'd0) begin
      tests_failed++;
      $display("FAIL async_reset_write: got we=%b busy=%b data=%h, want 0 0 0", ld_we, busy, ld_data);
    end
    tick();
    // Reset cut the WRITE cycle before its rising edge, so no write reaches memory.
    tests_run++;
    if (wr_addr_q.size() != 0) begin
      tests_failed++;
      $display("FAIL reset_in_write_log: got %0d writes want 0", wr_addr_q.size());
    end
    load_en = 1'b0; reset = 1'b1; tick();
  endtask

  initial begin
    test_reset();
    test_two_words();
    test_partial();
    test_second_session();
    test_back_to_back();
    test_overflow();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule

// File: doc/mem_loader.md
MEM_LOADER -- requirements
Module: mem_loader

Interface
REQ-001 Parameter DEPTH, default 256: number of 16-bit words in the target memory; the load stops after word DEPTH-1.
REQ-002 clk  input  1: single system clock; all state updates on rising edge.
REQ-003 reset  input  1: asynchronous, active-low; reset=0 forces the reset state immediately, independent of clk.
REQ-004 load_en  input  1: level; 1 = loading session active, 0 = end or abort session.
REQ-005 byte_in  input  8: incoming data byte, valid only while byte_vld=1.
REQ-006 byte_vld  input  1: one-cycle strobe per byte; bytes arrive high byte first, then low byte.
REQ-007 ld_we  output  1: memory write enable, one-cycle pulse per assembled word.
REQ-008 ld_addr  output  16: memory write address, zero-extended word index.
REQ-009 ld_data  output  16: memory write data {high byte, low byte}.
REQ-010 busy  output  1: 1 in states HI, LO and WRITE.
REQ-011 done  output  1: sticky completion flag.
REQ-012 err  output  1: sticky error flag (partial word or overflow).
REQ-013 word_cnt  output  16: number of words written in the current session.

Function
REQ-014 The FSM SHALL have states IDLE, HI, LO, WRITE and DONE; all outputs SHALL be registered.
REQ-015 IDLE: load_en=1 -> HI; ld_addr, word_cnt, done and err cleared on the same edge.
REQ-016 HI: byte_vld=1 -> high byte latched, next LO; load_en=0 with byte_vld=0 -> DONE, err unchanged.
REQ-017 LO: byte_vld=1 -> ld_data={latched high, byte_in}, next WRITE; load_en=0 with byte_vld=0 -> DONE with err=1, partial word discarded and never written.
REQ-018 byte_vld=1 SHALL take priority over load_en=0 in the same cycle in HI and LO.
REQ-019 WRITE: ld_we=1 for exactly one cycle with stable ld_addr and ld_data; on exit ld_addr and word_cnt increment by 1.
REQ-020 Latency: ld_we SHALL assert in the cycle immediately after the low-byte strobe cycle.
REQ-021 WRITE with ld_addr=DEPTH-1 (memory full) -> DONE; ld_addr SHALL saturate at DEPTH-1 and never wrap to 0.
REQ-022 WRITE, not full: byte_vld=1 -> byte latched as next high byte, next LO; otherwise -> HI.
REQ-023 WRITE at full with byte_vld=1 -> err=1, byte discarded.
REQ-024 DONE: done=1; byte_vld=1 while load_en=1 -> err=1 (overflow), byte ignored; load_en=0 -> IDLE with done and err retained.
REQ-025 ld_we SHALL never assert outside WRITE; no memory write SHALL occur after DONE is entered.
REQ-026 word_cnt SHALL equal the number of ld_we pulses since session start, range 0..DEPTH.

Reset
REQ-027 reset=0 SHALL force state IDLE, ld_we=0, ld_addr=0, ld_data=0, busy=0, done=0, err=0, word_cnt=0, and clear the high-byte latch.
REQ-028 Reset asserted mid-session SHALL abort the session with no further ld_we pulse, including from state WRITE.
REQ-029 After reset release, no load SHALL start unless load_en is sampled 1 while in IDLE.

Verification
REQ-030 load_en=1, bytes 12,34,AB,CD, then load_en=0 -> writes 0x1234@0 and 0xABCD@1, word_cnt=2, done=1, err=0.
REQ-031 load_en=1, bytes 12,34,56, then load_en=0 -> single write 0x1234@0, done=1, err=1, no write to address 1.
REQ-032 DEPTH=4, 10 bytes -> writes to addresses 0..3, ld_addr=3, word_cnt=4, done=1, err=1 (bytes 9-10 overflow).
REQ-033 Back-to-back strobes: byte_vld in the WRITE cycle -> byte captured as next high word byte, no data lost, ld_we cycle-exact after each low byte.
REQ-034 reset=0 pulsed asynchronously between clk edges while in LO -> all outputs 0 immediately, no ld_we; the next session starts at address 0.
REQ-035 Second session after DONE -> IDLE -> done, err and word_cnt cleared on start, writes resume at address 0.
